// File: rtl/usb_buf_pkg.sv
// ============================================================================
// Module      : usb_buf_pkg
// Description : Shared constants and types for the USB transmit data path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_buf_pkg;

    localparam int TX_BUF_DEPTH = 64;
    localparam int TX_BUF_PTR_W = 6;
    localparam int TX_BUF_OCC_W = 7;

    typedef logic [7:0] usb_byte_t;

    // Packet kind requested of the transmitter; shared with tx and the AHB slave.
    typedef enum logic [2:0] {
        TX_PKT_IDLE  = 3'd0,
        TX_PKT_DATA  = 3'd1,
        TX_PKT_ACK   = 3'd2,
        TX_PKT_NAK   = 3'd3,
        TX_PKT_STALL = 3'd4
    } tx_packet_t;

endpackage

`default_nettype wire

// File: rtl/usb_buf_ptr.sv
// ============================================================================
// Module      : usb_buf_ptr
// Description : Wrapping FIFO pointer register with enable and sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_buf_ptr
    import usb_buf_pkg::*;
#(
    parameter int W = TX_BUF_PTR_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Power-of-two depth: natural binary overflow provides the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/usb_tx_data_buffer.sv
// ============================================================================
// Module      : usb_tx_data_buffer
// Description : 64-byte first-word-fall-through FIFO feeding the USB tx.
//               TX_BUF_STICKY_ERR_EN makes the error flags sticky until clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_tx_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = TX_BUF_DEPTH,
    parameter int DATA_W = 8,
    parameter int OCC_W  = TX_BUF_OCC_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_tx_packet_data,
    input  logic              clear,
    output logic [DATA_W-1:0] tx_packet_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic              buffer_full,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] c_DEPTH = OCC_W'(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               w_empty;
    logic               w_pop_acc;
    logic               w_push_acc;

    assign w_empty    = (occ_q == '0);
    assign w_pop_acc  = !clear && get_tx_packet_data && !w_empty;
    // A full buffer still takes a push when the same edge frees a slot.
    assign w_push_acc = !clear && store_tx_data && ((occ_q < c_DEPTH) || w_pop_acc);

    usb_buf_ptr #(.W(c_PTR_W)) u_wr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en_i  (w_push_acc),
        .clr_i (clear),
        .ptr_o (w_wr_ptr)
    );

    usb_buf_ptr #(.W(c_PTR_W)) u_rd_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .en_i  (w_pop_acc),
        .clr_i (clear),
        .ptr_o (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem_q[w_wr_ptr] <= tx_data;
        end
    end

    always_comb begin
        occ_d = occ_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (clear) begin
            occ_d = '0;
        end else begin
            case ({w_push_acc, w_pop_acc})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
`ifdef TX_BUF_STICKY_ERR_EN
            ovf_d = ovf_q | (store_tx_data && !w_push_acc);
            udf_d = udf_q | (get_tx_packet_data && w_empty);
`else
            ovf_d = store_tx_data && !w_push_acc;
            udf_d = get_tx_packet_data && w_empty;
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign tx_packet_data   = w_empty ? '0 : mem_q[w_rd_ptr];
    assign buffer_occupancy = occ_q;
    assign buffer_full      = (occ_q == c_DEPTH);
    assign overflow_err     = ovf_q;
    assign underflow_err    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_data_buffer.sv
// ============================================================================
// Module      : tb_usb_tx_data_buffer
// Description : Self-checking bench for usb_tx_data_buffer (queue reference).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_tx_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic       clear;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       buffer_full;
    logic       overflow_err;
    logic       underflow_err;

    always #5 clk = ~clk;

    usb_tx_data_buffer dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .get_tx_packet_data (get_tx_packet_data),
        .clear              (clear),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .buffer_full        (buffer_full),
        .overflow_err       (overflow_err),
        .underflow_err      (underflow_err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    typedef struct {
        logic       st;
        logic [7:0] d;
        logic       g;
        logic [6:0] occ;
        logic [7:0] head;
    } vec_t;

    vec_t tbl[6];

`ifdef TX_BUF_STICKY_ERR_EN
    localparam logic c_STICKY = 1'b1;
`else
    localparam logic c_STICKY = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("occupancy", 32'(buffer_occupancy), 32'(sb_q.size()));
        chk("full", 32'(buffer_full), 32'(sb_q.size() == 64));
        chk("head", 32'(tx_packet_data), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'h0);
        chk("overflow", 32'(overflow_err), 32'(m_ovf));
        chk("underflow", 32'(underflow_err), 32'(m_udf));
    endtask

    // Called at a falling edge; drives one cycle, updates the reference, checks.
    task automatic cycle(input logic st, input logic [7:0] d, input logic g, input logic cl);
        logic pop_ok;
        logic push_ok;
        store_tx_data      = st;
        tx_data            = d;
        get_tx_packet_data = g;
        clear              = cl;
        #1;
        if (!cl && g && sb_q.size() != 0)
            chk("pop_data", 32'(tx_packet_data), 32'(sb_q[0]));
        if (cl) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = g && (sb_q.size() != 0);
            push_ok = st && ((sb_q.size() < 64) || pop_ok);
            m_ovf   = (c_STICKY && m_ovf) || (st && !push_ok);
            m_udf   = (c_STICKY && m_udf) || (g && sb_q.size() == 0);
            if (pop_ok)  void'(sb_q.pop_front());
            if (push_ok) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0;
        store_tx_data = 1'b0; tx_data = 8'h0; get_tx_packet_data = 1'b0; clear = 1'b0;
        tbl[0] = '{1'b1, 8'h18, 1'b0, 7'd1, 8'h18};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 7'd2, 8'h18};
        tbl[2] = '{1'b1, 8'h3C, 1'b0, 7'd3, 8'h18};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 7'd2, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 7'd1, 8'h3C};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 7'd0, 8'h00};
        repeat (2) @(negedge clk);
        check_state();
        n_rst = 1'b1;
        @(negedge clk);

        // Ordered pass-through with hand-written expectations
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].st, tbl[i].d, tbl[i].g, 1'b0);
            chk("tbl_occ", 32'(buffer_occupancy), 32'(tbl[i].occ));
            chk("tbl_head", 32'(tx_packet_data), 32'(tbl[i].head));
        end

        // Fill, overflow, drain
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(buffer_full), 32'd1);
        chk("fill_occ", 32'(buffer_occupancy), 32'd64);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(overflow_err), 32'd1);
        chk("ovf_occ", 32'(buffer_occupancy), 32'd64);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_after", 32'(overflow_err), 32'(c_STICKY));
        for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_occ", 32'(buffer_occupancy), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Walk pointers to 58 so the simultaneous ops straddle the wrap
        cycle(1'b1, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 57; i++) cycle(1'b1, 8'(8'h41 + i), 1'b1, 1'b0);
        for (int i = 0; i < 63; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        chk("wrap_full", 32'(buffer_full), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        chk("wrap_occ", 32'(buffer_occupancy), 32'd64);
        chk("wrap_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Push and get together on empty
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_both_occ", 32'(buffer_occupancy), 32'd1);
        chk("empty_both_udf", 32'(underflow_err), 32'd1);
        chk("empty_both_head", 32'(tx_packet_data), 32'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Clear beats a concurrent store
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clr_occ", 32'(buffer_occupancy), 32'd0);
        chk("clr_head", 32'(tx_packet_data), 32'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_still_empty", 32'(buffer_occupancy), 32'd0);

        // Underflow persistence depends on the build
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_first", 32'(underflow_err), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("udf_later", 32'(underflow_err), 32'(c_STICKY));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_cleared", 32'(underflow_err), 32'd0);

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h51 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        sb_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("rst_occ", 32'(buffer_occupancy), 32'd0);
        chk("rst_head", 32'(tx_packet_data), 32'h00);
        check_state();
        @(negedge clk);
        n_rst = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_rst_head", 32'(tx_packet_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_tx_data_buffer.md
Name: usb_tx_data_buffer

Overview:
- 64-byte circular FIFO directly upstream of the USB transmitter (tx).
- Host-side (AHB slave) writes payload bytes with store_tx_data.
- tx pops them with get_tx_packet_data and reads tx_packet_data; buffer_occupancy tells tx how many bytes remain, including when to end DATA payload and emit EOP.
- Provides flush/clear and reports overflow/underflow.

Parameters:
- DEPTH, 64, number of byte entries; must be a power of 2.
- DATA_W, 8, byte width.
- OCC_W, 7, occupancy width; must satisfy 2^OCC_W > DEPTH so the full count is representable.

Ports:
- clk  in  1  system clock; all state on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- store_tx_data  in  1  push tx_data this cycle.
- tx_data  in  8  byte from host side.
- get_tx_packet_data  in  1  pop request from tx.
- clear  in  1  synchronous empty; highest priority after reset.
- tx_packet_data  out  8  head byte, first-word-fall-through.
- buffer_occupancy  out  7  stored byte count, 0..64.
- buffer_full  out  1  occupancy == DEPTH.
- overflow_err  out  1  push dropped because the buffer was full.
- underflow_err  out  1  pop requested while empty.

Behaviour:
- Reset (n_rst low, async) clears wr_ptr, rd_ptr and occupancy to 0. All outputs read 0; memory contents are don't-care.
- Storage: DEPTH x DATA_W register array. wr_ptr and rd_ptr are log2(DEPTH) bits and wrap 63 -> 0 with no special case.
- tx_packet_data is combinational mem[rd_ptr] when occupancy != 0, else 8'h00. The byte is valid in the same cycle tx asserts get; tx sees the next byte in the following cycle.
- Priority, per rising edge:
  1. clear: pointers and occupancy go to 0; store and get that cycle are ignored; error flags go to 0.
  2. Otherwise, push is accepted iff store && (occupancy < DEPTH || get accepted same cycle). Accepted push writes mem[wr_ptr] and increments wr_ptr.
  3. Pop is accepted iff get && occupancy != 0. Accepted pop increments rd_ptr.
  4. occupancy next = occupancy + push_acc - pop_acc, never outside 0..DEPTH.
- Simultaneous push and pop:
  - Full: both accepted, occupancy stays 64.
  - Empty: push accepted, pop rejected; occupancy -> 1 and underflow_err asserts.
  - Partially filled: both accepted, occupancy unchanged.
- buffer_full is combinational from occupancy.
- Error flags are registered one-cycle pulses:
  - overflow_err = 1 in the cycle after a rejected push.
  - underflow_err = 1 in the cycle after a rejected pop.
  - Rejected operations never corrupt pointers or data.
- Latency: a pushed byte is visible on tx_packet_data and counted in buffer_occupancy the cycle after the push edge.
- Reset asserted mid-transfer aborts immediately; post-reset, tx sees occupancy 0.
- No internal state machine beyond counters. tx owns packet framing; this block never inspects data.

Optional Feature:
- Macro TX_BUF_STICKY_ERR_EN.
- Defined: overflow_err and underflow_err are sticky; they stay 1 until clear or reset, and a new error while set leaves them at 1.
- Undefined: single-cycle pulse behaviour as above.
- Push/pop behaviour is identical either way.

Decomposition:
- Package usb_buf_pkg holds:
  - localparams TX_BUF_DEPTH=64, TX_BUF_PTR_W=6, TX_BUF_OCC_W=7;
  - typedef logic [7:0] usb_byte_t;
  - the tx_packet encoding enum (IDLE/DATA/ACK/NAK/STALL), shared with tx and the AHB slave.
- One natural sub-module, usb_buf_ptr: a wrapping pointer register with enable and sync clear. It is instantiated twice (write and read).

Test Plan:
- Reset: drive n_rst low between clock edges -> tx_packet_data=0, buffer_occupancy=0, buffer_full=0, both errors 0, without waiting for a clock edge.
- Ordered pass-through: push 0x18, 0xA5, 0x3C on consecutive cycles -> occupancy 1,2,3. Then pulse get three times -> tx_packet_data shows 0xA5, 0x3C, then 0x00; occupancy 2,1,0.
- Fill/overflow: push bytes 0..63 -> occupancy 64, buffer_full=1. Push 0xFF -> overflow_err pulses one cycle, occupancy stays 64. Pop 64 times -> reads 0..63, so 0xFF was dropped.
- Wrap and simultaneous ops: fill to 64, then push+get together 10 cycles -> occupancy stays 64 and pops return in order across the 63->0 boundary. Push+get on empty -> occupancy 1, underflow_err=1.
- Clear: at occupancy 20, assert clear together with store -> next cycle occupancy 0, tx_packet_data 0x00, pushed byte absent.
- Sticky errors: build with TX_BUF_STICKY_ERR_EN, get on empty -> underflow_err remains 1 for 5+ cycles until clear. Same sequence without the macro -> 1-cycle pulse.
